// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator.
// Holds row/column codes, the key-to-position map, FSM states and game keys.
package keypad_pkg;

    localparam logic [3:0] ROW0     = 4'b1110;
    localparam logic [3:0] ROW1     = 4'b1101;
    localparam logic [3:0] ROW2     = 4'b1011;
    localparam logic [3:0] ROW3     = 4'b0111;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    localparam logic [3:0] KEY_FIRE  = 4'h1;
    localparam logic [3:0] KEY_LEFT  = 4'h9;
    localparam logic [3:0] KEY_RIGHT = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } kpState_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } keyPos_t;

    // Membrane layout: each row lists columns c0..c3.
    function automatic keyPos_t keyPos(input logic [3:0] key);
        keyPos_t p;
        p = '0;
        case (key)
            4'h7: p = {2'd0, 2'd0};
            4'h4: p = {2'd0, 2'd1};
            4'h1: p = {2'd0, 2'd2};
            4'h0: p = {2'd0, 2'd3};
            4'h8: p = {2'd1, 2'd0};
            4'h5: p = {2'd1, 2'd1};
            4'h2: p = {2'd1, 2'd2};
            4'hA: p = {2'd1, 2'd3};
            4'h9: p = {2'd2, 2'd0};
            4'h6: p = {2'd2, 2'd1};
            4'h3: p = {2'd2, 2'd2};
            4'hB: p = {2'd2, 2'd3};
            4'hC: p = {2'd3, 2'd0};
            4'hD: p = {2'd3, 2'd1};
            4'hE: p = {2'd3, 2'd2};
            4'hF: p = {2'd3, 2'd3};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/keypad_col_drive.sv
// Registered row-strobe to column-sense responder.
// Ports: clk, rst (sync, low), key_down, r, c, keypadRow in; keypadCol out.
module keypad_col_drive
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_down,
    input  logic [1:0] r,
    input  logic [1:0] c,
    input  logic [3:0] keypadRow,
    output logic [3:0] keypadCol
);

    logic [3:0] colSel;

    assign colSel = 4'b0001 << c;

    // Only the key's own row pulls its column low; other strobed
    // rows do not mask it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            keypadCol <= COL_IDLE;
        end else if (key_down && !keypadRow[r]) begin
            keypadCol <= ~colSel;
        end else begin
            keypadCol <= COL_IDLE;
        end
    end

endmodule

// File: rtl/keypad_matrix_emu.sv
// 4x4 membrane keypad emulator: scripted press/gap commands to matrix lines.
// Ports: cmd_* valid/ready command in, abort, keypadRow in; keypadCol,
// key_down, busy, done out. clk, rst (sync, active-low).
module keypad_matrix_emu
    import keypad_pkg::*;
#(
    parameter int HOLD_W     = 25,
    parameter int BOUNCE_LEN = 0,
    parameter int BOUNCE_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [HOLD_W-1:0] cmd_gap,
    input  logic              abort,
    input  logic [3:0]        keypadRow,
    output logic [3:0]        keypadCol,
    output logic              key_down,
    output logic              busy,
    output logic              done
);

    localparam int BCW =
        (BOUNCE_DIV > 1) ? $clog2(BOUNCE_DIV) : 1;
    localparam logic [BCW-1:0] BNC_TOP =
        BCW'(BOUNCE_DIV - 1);
    localparam int BL_IDX =
        (BOUNCE_LEN > 0) ? BOUNCE_LEN - 1 : 0;
    localparam logic [HOLD_W-1:0] BNC_LAST =
        HOLD_W'(BL_IDX);
    localparam bit BNC_ON = (BOUNCE_LEN > 0);

    kpState_t          state;
    kpState_t          nxt;
    logic              fin;
    logic              accept;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cntInc;
    logic [3:0]        keyQ;
    logic [HOLD_W-1:0] holdQ;
    logic [HOLD_W-1:0] gapQ;
    logic              doneQ;
    logic [BCW-1:0]    bncCnt;
    logic              bncLvl;
    logic              inBounce;
    keyPos_t           pos;

    assign accept = cmd_valid & cmd_ready;
    assign cntInc = (cnt == '1) ? cnt : cnt + HOLD_W'(1);
    assign pos    = keyPos(keyQ);
    assign done   = doneQ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // fin marks the edge after which done is shown for one cycle.
    always_comb begin
        nxt = state;
        fin = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_hold != '0) begin
                        nxt = PRESS;
                    end else if (cmd_gap != '0) begin
                        nxt = GAP;
                    end else begin
                        fin = 1'b1;
                    end
                end
            end
            PRESS: begin
                if (abort) begin
                    nxt = IDLE;
                    fin = 1'b1;
                end else if (cnt == holdQ - HOLD_W'(1)) begin
                    if (gapQ != '0) begin
                        nxt = GAP;
                    end else begin
                        nxt = IDLE;
                        fin = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort || cnt == gapQ - HOLD_W'(1)) begin
                    nxt = IDLE;
                    fin = 1'b1;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        key_down  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = rst;
            end
            PRESS: begin
                busy     = 1'b1;
                key_down = inBounce ? bncLvl : 1'b1;
            end
            GAP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            keyQ     <= '0;
            holdQ    <= '0;
            gapQ     <= '0;
            doneQ    <= 1'b0;
            bncCnt   <= '0;
            bncLvl   <= 1'b0;
            inBounce <= 1'b0;
        end else begin
            doneQ <= fin;

            // Counter restarts on every state change.
            if (nxt != state) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cntInc;
            end

            if (accept) begin
                keyQ  <= cmd_key;
                holdQ <= cmd_hold;
                gapQ  <= cmd_gap;
            end else if (abort && state != IDLE) begin
                keyQ  <= '0;
                holdQ <= '0;
                gapQ  <= '0;
            end

            // Contact starts closed and flips every BOUNCE_DIV cycles
            // until the chatter window runs out.
            if (nxt == PRESS && state != PRESS) begin
                bncCnt   <= '0;
                bncLvl   <= 1'b1;
                inBounce <= BNC_ON;
            end else if (state == PRESS) begin
                if (bncCnt == BNC_TOP) begin
                    bncCnt <= '0;
                    bncLvl <= ~bncLvl;
                end else begin
                    bncCnt <= bncCnt + BCW'(1);
                end
                if (cnt == BNC_LAST) begin
                    inBounce <= 1'b0;
                end
            end
        end
    end

    keypad_col_drive uColDrive (
        .clk       (clk),
        .rst       (rst),
        .key_down  (key_down),
        .r         (pos.row),
        .c         (pos.col),
        .keypadRow (keypadRow),
        .keypadCol (keypadCol)
    );

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Scoreboard bench for keypad_matrix_emu: clean and chattering instances.
// Expected per-cycle outputs are queued at drive time, checked at negedge.
module tb_keypad_matrix_emu;

    localparam int HW    = 25;
    localparam int B_LEN = 8;
    localparam int B_DIV = 2;

    logic          clk = 1'b0;
    logic          rst;

    logic          aValid, aReady, aAbort, aKd, aBusy, aDone;
    logic [3:0]    aKey, aRow, aCol;
    logic [HW-1:0] aHold, aGap;

    logic          bValid, bReady, bAbort, bKd, bBusy, bDone;
    logic [3:0]    bKey, bRow, bCol;
    logic [HW-1:0] bHold, bGap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         sel;
        logic [3:0] col;
        logic       kd;
        logic       dn;
        logic       rdy;
        logic       bsy;
    } exp_t;

    exp_t sb[$];

    int layout[16] = '{7, 4, 1, 0,
                       8, 5, 2, 10,
                       9, 6, 3, 11,
                       12, 13, 14, 15};

    always #5 clk = ~clk;

    keypad_matrix_emu #(.HOLD_W(HW)) dutA (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (aValid),
        .cmd_ready (aReady),
        .cmd_key   (aKey),
        .cmd_hold  (aHold),
        .cmd_gap   (aGap),
        .abort     (aAbort),
        .keypadRow (aRow),
        .keypadCol (aCol),
        .key_down  (aKd),
        .busy      (aBusy),
        .done      (aDone)
    );

    keypad_matrix_emu #(
        .HOLD_W     (HW),
        .BOUNCE_LEN (B_LEN),
        .BOUNCE_DIV (B_DIV)
    ) dutB (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (bValid),
        .cmd_ready (bReady),
        .cmd_key   (bKey),
        .cmd_hold  (bHold),
        .cmd_gap   (bGap),
        .abort     (bAbort),
        .keypadRow (bRow),
        .keypadCol (bCol),
        .key_down  (bKd),
        .busy      (bBusy),
        .done      (bDone)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t",
                     tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (!e.sel) begin
                chk("colA",  32'(aCol),   32'(e.col));
                chk("kdA",   32'(aKd),    32'(e.kd));
                chk("doneA", 32'(aDone),  32'(e.dn));
                chk("rdyA",  32'(aReady), 32'(e.rdy));
                chk("busyA", 32'(aBusy),  32'(e.bsy));
            end else begin
                chk("colB",  32'(bCol),   32'(e.col));
                chk("kdB",   32'(bKd),    32'(e.kd));
                chk("doneB", 32'(bDone),  32'(e.dn));
                chk("rdyB",  32'(bReady), 32'(e.rdy));
                chk("busyB", 32'(bBusy),  32'(e.bsy));
            end
        end
    end

    function automatic logic [3:0] rowAt(input bit rot,
                                         input logic [3:0] fix,
                                         input int n);
        if (!rot) return fix;
        case ((n / 4) % 4)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic chat(input bit sel,
                                  input int p,
                                  input int hold);
        int lim;
        if (!sel) return 1'b1;
        lim = (B_LEN < hold) ? B_LEN : hold;
        if (p < lim) return ((p / B_DIV) % 2) == 0;
        return 1'b1;
    endfunction

    task automatic drive(input bit sel, input logic v,
                         input logic [3:0] k, input int h,
                         input int g, input logic ab,
                         input logic [3:0] row);
        if (!sel) begin
            aValid = v; aKey = k; aAbort = ab; aRow = row;
            aHold = h[HW-1:0]; aGap = g[HW-1:0];
        end else begin
            bValid = v; bKey = k; bAbort = ab; bRow = row;
            bHold = h[HW-1:0]; bGap = g[HW-1:0];
        end
    endtask

    // Entered at posedge+1 of cycle 0 with the DUT idle; returns at
    // posedge+1 of the cycle that shows done.
    task automatic runCmd(input bit sel, input logic [3:0] key,
                          input int hold, input int gap,
                          input int abortAt, input bit rot,
                          input logic [3:0] fix, input bit keep,
                          input logic [3:0] nKey, input int nHold,
                          input int nGap);
        int r, c, nEnd;
        logic kd, kdPrev;
        logic [3:0] row, rowPrev, colBit;
        exp_t e;
        r = 0; c = 0;
        for (int i = 0; i < 16; i++)
            if (layout[i] == int'(key)) begin
                r = i / 4; c = i % 4;
            end
        if (abortAt >= 1 && abortAt <= hold + gap)
            nEnd = abortAt + 1;
        else
            nEnd = hold + gap + 1;
        row = rowAt(rot, fix, 0);
        drive(sel, 1'b1, key, hold, gap, abortAt == 0, row);
        kdPrev = 1'b0;
        rowPrev = row;
        for (int n = 1; n <= nEnd; n++) begin
            @(posedge clk);
            #1;
            row = rowAt(rot, fix, n);
            if (keep)
                drive(sel, 1'b1, nKey, nHold, nGap, 1'b0, row);
            else
                drive(sel, 1'b0, 4'h0, 0, 0, n == abortAt, row);
            if (!keep && n == abortAt) begin
                if (!sel) aAbort = 1'b1; else bAbort = 1'b1;
            end
            if (keep && n == abortAt) begin
                if (!sel) aAbort = 1'b1; else bAbort = 1'b1;
            end
            kd = (n < nEnd && n <= hold) ? chat(sel, n - 1, hold) : 1'b0;
            colBit = 4'b0001 << c;
            e.sel = sel;
            e.col = (kdPrev && !rowPrev[r]) ? ~colBit : 4'hF;
            e.kd  = kd;
            e.dn  = (n == nEnd);
            e.rdy = (n == nEnd);
            e.bsy = (n != nEnd);
            sb.push_back(e);
            kdPrev = kd;
            rowPrev = row;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 0, 0, 1'b0, 4'hF);
        drive(1'b1, 1'b0, 4'h0, 0, 0, 1'b0, 4'hF);
        @(posedge clk);
        @(negedge clk);
        chk("rstColA", 32'(aCol), 32'hF);
        chk("rstColB", 32'(bCol), 32'hF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("relColA",  32'(aCol),   32'hF);
        chk("relRdyA",  32'(aReady), 32'h1);
        chk("relBusyA", 32'(aBusy),  32'h0);
        chk("relDoneA", 32'(aDone),  32'h0);
        chk("relKdA",   32'(aKd),    32'h0);
        chk("relRdyB",  32'(bReady), 32'h1);
        chk("relColB",  32'(bCol),   32'hF);
        @(posedge clk);
        #1;

        runCmd(0, 4'h1, 20, 5, -1, 0, 4'b1110, 0, 0, 0, 0);
        runCmd(0, 4'hC, 50, 0, -1, 1, 4'hF, 0, 0, 0, 0);
        runCmd(0, 4'h9, 30, 0, 10, 0, 4'b1011, 0, 0, 0, 0);
        runCmd(0, 4'h5, 0, 0, -1, 0, 4'b1101, 0, 0, 0, 0);
        runCmd(0, 4'h2, 0, 3, -1, 0, 4'b1101, 0, 0, 0, 0);
        runCmd(0, 4'hF, 4, 3, 0, 0, 4'b0111, 1, 4'h0, 2, 2);
        runCmd(0, 4'h0, 2, 2, -1, 0, 4'b1110, 0, 0, 0, 0);
        runCmd(0, 4'hA, 3, 10, 5, 0, 4'b1101, 0, 0, 0, 0);
        runCmd(0, 4'h1, 1, 0, -1, 0, 4'b1110, 0, 0, 0, 0);

        runCmd(1, 4'h7, 12, 0, -1, 0, 4'b1110, 0, 0, 0, 0);
        runCmd(1, 4'h4, 3, 2, -1, 0, 4'b1110, 0, 0, 0, 0);

        drive(0, 1'b1, 4'h1, 100, 0, 1'b0, 4'b1110);
        @(posedge clk);
        #1 drive(0, 1'b0, 4'h0, 0, 0, 1'b0, 4'b1110);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("midKd", 32'(aKd), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mrKd",   32'(aKd),    32'h0);
        chk("mrDone", 32'(aDone),  32'h0);
        chk("mrBusy", 32'(aBusy),  32'h0);
        chk("mrRdy",  32'(aReady), 32'h1);
        chk("mrCol",  32'(aCol),   32'hF);
        @(negedge clk);
        chk("mrDone2", 32'(aDone), 32'h0);
        chk("mrKd2",   32'(aKd),   32'h0);

        chk("sbDrained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_emu.md
Name: keypad_matrix_emu

Overview:
Synthesizable model of the 4x4 membrane keypad, the device end of the row-strobe/column-sense matrix protocol. It takes key commands (key code, hold time, release gap) over a valid/ready port and answers the scanner's active-low row strobes with active-low column lines. It lets the game logic (fire, move left/right) be driven hands-free from a script source such as a UART bridge, or from a bench.

Parameters:
HOLD_W, 25, width of the hold and gap counters in clk cycles
BOUNCE_LEN, 0, number of cycles at press start during which contact chatters (0 = clean press)
BOUNCE_DIV, 4, chatter half-period in clk cycles; must be 1 or more

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  emulator can accept a command
cmd_key  input  4  key code 0x0-0xF
cmd_hold  input  HOLD_W  press duration in cycles
cmd_gap  input  HOLD_W  released time after the press, in cycles
abort  input  1  force immediate release and return to IDLE
keypadRow  input  4  row strobes from scanner, active-low
keypadCol  output  4  column sense to scanner, active-low, idle 4'b1111
key_down  output  1  modelled contact currently closed
busy  output  1  command in progress
done  output  1  one-cycle pulse when a command completes or is aborted

Behaviour:
- Reset (rst=0 at posedge): state IDLE; keypadCol=4'b1111; key_down=0; busy=0; done=0; cmd_ready=1 after reset is released; counters=0.
- Key map: key code to (row index r, column index c). The strobe for row r is keypadRow[r]=0 (row0 = 4'b1110). Column c is reported as keypadCol[c]=0.
  - row0: 7,4,1,0
  - row1: 8,5,2,A
  - row2: 9,6,3,B
  - row3: C,D,E,F
  - Within each row, columns c0..c3 are in the order listed.
- keypadCol is registered, one cycle of latency. Each cycle, if key_down=1 and keypadRow[r]=0, keypadCol is all ones except bit c=0; otherwise 4'b1111. A key press is reported only when its own row is strobed. If several rows are low at once, the press is still reported.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch key, hold and gap. Go to PRESS if hold>0, else to GAP if gap>0, else stay IDLE and pulse done the next cycle.
  - PRESS: cmd_ready=0, busy=1. The counter counts hold cycles. key_down=1 for exactly hold cycles, except during chatter. Then go to GAP, or to IDLE with done if gap=0.
  - GAP: key_down=0 for exactly gap cycles, then go to IDLE and pulse done.
- Chatter: for the first min(BOUNCE_LEN, hold) cycles of PRESS, key_down starts at 1 and toggles every BOUNCE_DIV cycles. Chatter cycles count toward hold.
- abort (any state other than IDLE): next cycle key_down=0, state IDLE, done=1. The latched command is discarded. abort in IDLE is ignored. If cmd_valid and abort are high together in IDLE, the command is accepted.
- Commands are never queued. cmd_ready drops the cycle after acceptance and returns with the first IDLE cycle.
- Counters saturate; no wrap. The full range of hold (2^HOLD_W - 1) is supported.
- Reset asserted mid-command wins over everything. No done pulse is generated on reset.

Decomposition:
- Package keypad_pkg holds:
  - row strobe constants ROW0..ROW3 (4'b1110, 4'b1101, 4'b1011, 4'b0111) and COL_IDLE=4'b1111;
  - the key-to-(row, col) lookup function;
  - state enum IDLE/PRESS/GAP;
  - game key constants KEY_FIRE=4'h1, KEY_LEFT=4'h9, KEY_RIGHT=4'hC.
- One sub-module is natural: keypad_col_drive, the registered row-to-column responder, with inputs key_down, r, c and keypadRow.

Test Plan:
- Reset with rst=0 for 3 cycles -> keypadCol=4'b1111, cmd_ready=1, busy=0, done=0.
- Command key=0x1, hold=20, gap=5, with keypadRow held at 4'b1110 -> keypadCol=4'b1011 for 20 cycles, starting 2 cycles after acceptance; then 4'b1111; done pulses 25 cycles after PRESS entry.
- Command key=0xC, hold=50, with keypadRow rotating 1110, 1101, 1011, 0111 every 4 cycles -> keypadCol=4'b1110 only one cycle after each 0111 strobe, 4'b1111 otherwise.
- Command key=0x9, hold=30, gap=0, abort asserted at press cycle 10 -> key_down falls the next cycle, done=1 once, cmd_ready=1, no GAP state entered.
- BOUNCE_LEN=8, BOUNCE_DIV=2, command key=0x7, hold=12, row0 strobed -> key_down pattern 1,1,0,0,1,1,0,0 then 1 for 4 cycles; keypadCol follows, delayed one cycle, between 4'b1110 and 4'b1111.
- Command key=0x5, hold=0, gap=0 -> no press observed, done pulses the cycle after acceptance; a command presented during busy is held off (cmd_ready=0) until IDLE.
